// File: rtl/bus_slave_demux_pkg.sv
// Shared definitions for the slave-side bus demultiplexer: FSM state encoding,
// region codes and one-hot slave-select constants.
package bus_slave_demux_pkg;

   // Binary state encoding; 2'd3 is unused and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   // Default region codes held in the top address bits.
   localparam logic [1:0] S0_REG_DEF = 2'b00;
   localparam logic [1:0] S1_REG_DEF = 2'b01;

   // One-hot slave selects.
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_S0   = 2'b01;
   localparam logic [1:0] SEL_S1   = 2'b10;

   // Default number of ACCESS cycles allowed before an access is abandoned.
   localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/bus_slave_demux_if.sv
// Bus bundle between the master-select mux output, the demux and the two slave ports.
interface bus_slave_demux_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
) ();

   // Master side
   logic          m_req;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_ack;
   logic          m_err;
   logic [DW-1:0] m_rdata;

   // Slave side
   logic [1:0]    s_sel;
   logic          s_wr;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic          s_ack0;
   logic          s_ack1;
   logic [DW-1:0] s_rdata0;
   logic [DW-1:0] s_rdata1;

   // View of the demux itself: a slave towards the master, a master towards the slaves.
   modport demux (
      input  m_req, m_wr, m_addr, m_wdata,
      output m_ack, m_err, m_rdata,
      output s_sel, s_wr, s_addr, s_wdata,
      input  s_ack0, s_ack1, s_rdata0, s_rdata1
   );

   // Upstream bus master (after the master-select mux).
   modport master (
      output m_req, m_wr, m_addr, m_wdata,
      input  m_ack, m_err, m_rdata
   );

   // Downstream slave pair.
   modport slave (
      input  s_sel, s_wr, s_addr, s_wdata,
      output s_ack0, s_ack1, s_rdata0, s_rdata1
   );

endinterface

// File: rtl/bus_slave_demux_addr_dec.sv
// Region decoder: maps the two top address bits onto a one-hot slave select.
// Purely combinational; codes other than S0_REG/S1_REG report no hit.
module bus_slave_demux_addr_dec
   import bus_slave_demux_pkg::*;
#(
   parameter logic [1:0] S0_REG = S0_REG_DEF,
   parameter logic [1:0] S1_REG = S1_REG_DEF
) (
   input  logic [1:0] region,
   output logic       hit,
   output logic [1:0] sel
);

   // Region code -> one-hot select; slave 0 has priority if codes ever alias.
   always_comb begin
      sel = SEL_NONE;
      if (region == S0_REG) begin
         sel = SEL_S0;
      end else if (region == S1_REG) begin
         sel = SEL_S1;
      end
      hit = (sel != SEL_NONE);
   end

endmodule

// File: rtl/bus_slave_demux.sv
// Slave-side bus demultiplexer. Latches a master request, routes it to one of two
// slaves by address region, waits for that slave's ack (or a timeout) and returns
// a one-cycle m_ack with registered m_rdata / m_err.
module bus_slave_demux
   import bus_slave_demux_pkg::*;
#(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 32,
   parameter logic [1:0]  S0_REG  = S0_REG_DEF,
   parameter logic [1:0]  S1_REG  = S1_REG_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input logic               clk,
   input logic               reset,
   bus_slave_demux_if.demux  bus
);

   localparam int unsigned    CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q;
   logic [1:0]    sel_q;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [CW-1:0] count_q;
   logic          ack_q;
   logic          err_q;
   logic [DW-1:0] rdata_q;

   logic          dec_hit;
   logic [1:0]    dec_sel;
   logic          slave_ack;
   logic [DW-1:0] slave_rdata;

   // Decoding the live address in IDLE equals decoding the value latched on the same edge.
   bus_slave_demux_addr_dec #(
      .S0_REG (S0_REG),
      .S1_REG (S1_REG)
   ) u_addr_dec (
      .region (bus.m_addr[AW-1:AW-2]),
      .hit    (dec_hit),
      .sel    (dec_sel)
   );

   // Observe only the selected slave; the other slave's ack and data are ignored.
   always_comb begin
      slave_ack   = 1'b0;
      slave_rdata = '0;
      if (sel_q[0]) begin
         slave_ack   = bus.s_ack0;
         slave_rdata = bus.s_rdata0;
      end else if (sel_q[1]) begin
         slave_ack   = bus.s_ack1;
         slave_rdata = bus.s_rdata1;
      end
   end

   // Request latch, response capture, timeout counter and IDLE/ACCESS/RESP control.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         sel_q   <= SEL_NONE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            StIdle: begin
               sel_q   <= SEL_NONE;
               count_q <= '0;
               if (bus.m_req) begin
                  wr_q    <= bus.m_wr;
                  addr_q  <= bus.m_addr;
                  wdata_q <= bus.m_wdata;
                  if (dec_hit) begin
                     sel_q   <= dec_sel;
                     state_q <= StAccess;
                  end else begin
                     // Unmapped region: answer at once with an error.
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     ack_q   <= 1'b1;
                     state_q <= StResp;
                  end
               end
            end

            StAccess: begin
               if (slave_ack) begin
                  // Ack beats a coincident timeout.
                  rdata_q <= wr_q ? '0 : slave_rdata;
                  err_q   <= 1'b0;
                  ack_q   <= 1'b1;
                  sel_q   <= SEL_NONE;
                  count_q <= '0;
                  state_q <= StResp;
               end else if (count_q == CNT_LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  ack_q   <= 1'b1;
                  sel_q   <= SEL_NONE;
                  count_q <= '0;
                  state_q <= StResp;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end

            StResp: begin
               sel_q   <= SEL_NONE;
               count_q <= '0;
               state_q <= StIdle;
            end

            default: begin
               // Illegal code: return to IDLE with outputs cleared.
               sel_q   <= SEL_NONE;
               count_q <= '0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.m_ack   = ack_q;
   assign bus.m_err   = err_q;
   assign bus.m_rdata = rdata_q;
   assign bus.s_sel   = sel_q;
   assign bus.s_wr    = wr_q;
   assign bus.s_addr  = addr_q;
   assign bus.s_wdata = wdata_q;

endmodule
